cpu_hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage LEGv8 CPU; sits beside cpu_controlpath.

---
 rtl/cpu_hazard_if.sv | 45 ++++
 rtl/cpu_hazard_controller.sv | 146 ++++++++++++++
 tb/tb_cpu_hazard_controller.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_hazard_if.sv
// Hazard-controller bus: ID/EX/MEM pipeline observations in, stage enables and status out.
// The master is the CPU datapath/controlpath side; the slave is cpu_hazard_controller.
interface cpu_hazard_if #(
  parameter int CNT_WIDTH = 32
);
  logic [4:0]           id_Rn;
  logic [4:0]           id_Rm;
  logic [4:0]           id_Rd;
  logic                 id_Reg2Loc;
  logic                 id_reads_Ra;
  logic                 id_reads_Rb;
  logic                 id_is_bcond;
  logic                 id_br_taken;
  logic [4:0]           ex_Rd;
  logic                 ex_RegWren;
  logic                 ex_Mem2Reg;
  logic                 ex_SetFlags;
  logic                 dmem_req;
  logic                 dmem_ready;
  logic                 pc_wren;
  logic                 if_id_wren;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 pipe_freeze;
  logic                 mem_err;
  logic [1:0]           hz_state;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output id_Rn, id_Rm, id_Rd, id_Reg2Loc, id_reads_Ra, id_reads_Rb,
           id_is_bcond, id_br_taken, ex_Rd, ex_RegWren, ex_Mem2Reg,
           ex_SetFlags, dmem_req, dmem_ready,
    input  pc_wren, if_id_wren, if_id_flush, id_ex_bubble, pipe_freeze,
           mem_err, hz_state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_Rn, id_Rm, id_Rd, id_Reg2Loc, id_reads_Ra, id_reads_Rb,
           id_is_bcond, id_br_taken, ex_Rd, ex_RegWren, ex_Mem2Reg,
           ex_SetFlags, dmem_req, dmem_ready,
    output pc_wren, if_id_wren, if_id_flush, id_ex_bubble, pipe_freeze,
           mem_err, hz_state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/cpu_hazard_controller.sv
// LEGv8 pipeline hazard sequencer: load-use/flag stalls, dmem freeze with timeout, branch squash.
// Define HAZARD_BRANCH_FLUSH_EN to squash IF/ID on taken branches; otherwise delay-slot semantics.
//
// state | meaning
// RUN   | normal flow, hazards evaluated
// RSVD  | unused encoding, returns to RUN
// MEMW  | pipeline frozen awaiting dmem_ready
// ERR   | memory timeout, frozen until reset
module cpu_hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic         clk,
  input  logic         reset,
  cpu_hazard_if.slave  hz_if
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_RSVD = 2'b01,
    ST_MEMW = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  localparam int            WW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;

  logic [4:0] port_b_reg;
  logic       load_use;
  logic       flag_hz;
  logic       hz;
  logic       freeze;
  logic       flush;
  logic       unused_br;

  always_comb begin
    port_b_reg = hz_if.id_Reg2Loc ? hz_if.id_Rm : hz_if.id_Rd;
    // X31 is XZR: a load into it never produces a value worth waiting for
    load_use = hz_if.ex_RegWren && hz_if.ex_Mem2Reg && (hz_if.ex_Rd != 5'd31) &&
               ((hz_if.id_reads_Ra && (hz_if.ex_Rd == hz_if.id_Rn)) ||
                (hz_if.id_reads_Rb && (hz_if.ex_Rd == port_b_reg)));
    flag_hz  = hz_if.id_is_bcond && hz_if.ex_SetFlags;
    hz       = load_use || flag_hz;
    freeze   = ((state_q == ST_RUN) && hz_if.dmem_req && !hz_if.dmem_ready) ||
               ((state_q == ST_MEMW) && !hz_if.dmem_ready) ||
               (state_q == ST_ERR);
`ifdef HAZARD_BRANCH_FLUSH_EN
    flush    = hz_if.id_br_taken && (state_q == ST_RUN) && !hz && !freeze;
`else
    flush    = 1'b0;
`endif
  end

  assign unused_br = hz_if.id_br_taken;

  // Freeze dominates the hazard stall, which dominates the branch squash
  always_comb begin
    hz_if.pc_wren      = 1'b1;
    hz_if.if_id_wren   = 1'b1;
    hz_if.if_id_flush  = 1'b0;
    hz_if.id_ex_bubble = 1'b0;
    hz_if.pipe_freeze  = 1'b0;
    if (reset) begin
      hz_if.pc_wren      = 1'b0;
      hz_if.if_id_wren   = 1'b0;
      hz_if.if_id_flush  = 1'b1;
      hz_if.id_ex_bubble = 1'b1;
    end else if (freeze) begin
      hz_if.pc_wren     = 1'b0;
      hz_if.if_id_wren  = 1'b0;
      hz_if.pipe_freeze = 1'b1;
    end else if (hz) begin
      hz_if.pc_wren      = 1'b0;
      hz_if.if_id_wren   = 1'b0;
      hz_if.id_ex_bubble = 1'b1;
    end else begin
      hz_if.if_id_flush = flush;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    stall_d = stall_q;
    flush_d = flush_q;
    case (state_q)
      ST_RUN: begin
        if (hz_if.dmem_req && !hz_if.dmem_ready) begin
          state_d = ST_MEMW;
          wait_d  = WW'(1);
        end
      end
      ST_MEMW: begin
        if (hz_if.dmem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
    if ((hz || freeze) && (state_q != ST_ERR) && (stall_q != '1))
      stall_d = stall_q + CNT_WIDTH'(1);
    if (flush && (flush_q != '1))
      flush_d = flush_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz_if.hz_state  = state_q;
  assign hz_if.mem_err   = err_q;
  assign hz_if.stall_cnt = stall_q;
  assign hz_if.flush_cnt = flush_q;

endmodule

// File: tb/tb_cpu_hazard_controller.sv
// Bench for cpu_hazard_controller: directed pins plus randomized traffic against a behavioural model.
// Small MEM_TIMEOUT and CNT_WIDTH keep timeouts and counter saturation reachable.
module tb_cpu_hazard_controller;

  localparam int MT  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef HAZARD_BRANCH_FLUSH_EN
  localparam logic FLUSH_EXP = 1'b1;
`else
  localparam logic FLUSH_EXP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  cpu_hazard_if #(.CNT_WIDTH(CW)) bus ();

  cpu_hazard_controller #(.MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic fl;
    logic bub;
    logic frz;
  } exp_t;

  // Model state: waiting on memory, consecutive frozen cycles, sticky error, counters
  bit m_wait   = 1'b0;
  int m_frozen = 0;
  bit m_err    = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;
  exp_t ce;
  exp_t ue;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t expected();
    exp_t e;
    logic [4:0] b_reg;
    bit lu, fh, frz;
    e = '0;
    if (reset) begin
      e.fl  = 1'b1;
      e.bub = 1'b1;
      return e;
    end
    b_reg = bus.id_Reg2Loc ? bus.id_Rm : bus.id_Rd;
    lu = bus.ex_RegWren && bus.ex_Mem2Reg && (bus.ex_Rd != 5'd31) &&
         ((bus.id_reads_Ra && bus.ex_Rd == bus.id_Rn) ||
          (bus.id_reads_Rb && bus.ex_Rd == b_reg));
    fh = bus.id_is_bcond && bus.ex_SetFlags;
    if (m_err)       frz = 1'b1;
    else if (m_wait) frz = !bus.dmem_ready;
    else             frz = bus.dmem_req && !bus.dmem_ready;
    if (frz) e.frz = 1'b1;
    else if (lu || fh) e.bub = 1'b1;
    else begin
      e.pc   = 1'b1;
      e.ifid = 1'b1;
      e.fl   = FLUSH_EXP && bus.id_br_taken && !m_wait;
    end
    return e;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wait = 0; m_frozen = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      ue = expected();
      if (ue.frz) begin
        if (!m_err) begin
          m_stall  = sat_inc(m_stall);
          m_frozen = m_frozen + 1;
          m_wait   = 1'b1;
          if (m_frozen == MT) m_err = 1'b1;
        end
      end else begin
        m_wait   = 1'b0;
        m_frozen = 0;
        if (ue.bub) m_stall = sat_inc(m_stall);
      end
      if (ue.fl) m_flush = sat_inc(m_flush);
    end
  end

  always @(negedge clk) begin
    ce = expected();
    chk("pc_wren",      bus.pc_wren,      ce.pc);
    chk("if_id_wren",   bus.if_id_wren,   ce.ifid);
    chk("if_id_flush",  bus.if_id_flush,  ce.fl);
    chk("id_ex_bubble", bus.id_ex_bubble, ce.bub);
    chk("pipe_freeze",  bus.pipe_freeze,  ce.frz);
    chk("hz_state",     bus.hz_state,     m_err ? 2'b11 : (m_wait ? 2'b10 : 2'b00));
    chk("mem_err",      bus.mem_err,      m_err);
    chk("stall_cnt",    bus.stall_cnt,    m_stall);
    chk("flush_cnt",    bus.flush_cnt,    m_flush);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_Rn = 5'd0; bus.id_Rm = 5'd0; bus.id_Rd = 5'd0;
    bus.id_Reg2Loc = 0; bus.id_reads_Ra = 0; bus.id_reads_Rb = 0;
    bus.id_is_bcond = 0; bus.id_br_taken = 0;
    bus.ex_Rd = 5'd31; bus.ex_RegWren = 0; bus.ex_Mem2Reg = 0; bus.ex_SetFlags = 0;
    bus.dmem_req = 0; bus.dmem_ready = 1;
  endtask

  task automatic load_use_on();
    bus.ex_Mem2Reg = 1; bus.ex_RegWren = 1; bus.ex_Rd = 5'd5;
    bus.id_Rn = 5'd5; bus.id_reads_Ra = 1;
  endtask

  task automatic pulse_reset();
    cyc(); reset = 1'b1; idle();
    @(negedge clk);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_out", bus.if_id_flush, 1);
    cyc(); reset = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    int r;
    r = $urandom_range(4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  int hold_lo;

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // load-use stall for one cycle
    load_use_on();
    @(negedge clk);
    chk("t1_pc_wren", bus.pc_wren, 0);
    chk("t1_bubble", bus.id_ex_bubble, 1);
    cyc(); idle();
    @(negedge clk);
    chk("t1_stall_cnt", bus.stall_cnt, 1);
    chk("t1_pc_after", bus.pc_wren, 1);

    // XZR destination and Reg2Loc-selected mismatch: no stall
    cyc(); bus.ex_Mem2Reg = 1; bus.ex_RegWren = 1; bus.ex_Rd = 5'd31;
    bus.id_Rn = 5'd31; bus.id_reads_Ra = 1;
    @(negedge clk);
    chk("t2_xzr_bubble", bus.id_ex_bubble, 0);
    cyc(); idle(); bus.ex_Mem2Reg = 1; bus.ex_RegWren = 1; bus.ex_Rd = 5'd5;
    bus.id_Reg2Loc = 1; bus.id_Rm = 5'd6; bus.id_Rd = 5'd5; bus.id_reads_Rb = 1;
    @(negedge clk);
    chk("t2_r2l_bubble", bus.id_ex_bubble, 0);
    cyc(); idle();
    @(negedge clk);
    chk("t2_stall_cnt", bus.stall_cnt, 1);

    // taken branch, then taken branch under load-use
    bus.id_br_taken = 1;
    @(negedge clk);
    chk("t3_flush", bus.if_id_flush, FLUSH_EXP);
    cyc(); idle();
    @(negedge clk);
    chk("t3_flush_cnt", bus.flush_cnt, FLUSH_EXP);
    cyc(); load_use_on(); bus.id_br_taken = 1;
    @(negedge clk);
    chk("t3_lu_flush", bus.if_id_flush, 0);
    chk("t3_lu_bubble", bus.id_ex_bubble, 1);

    // three frozen cycles then ready
    pulse_reset();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_freeze", bus.pipe_freeze, 1);
      chk("t4_state", bus.hz_state, (i == 0) ? 2'b00 : 2'b10);
      cyc();
    end
    bus.dmem_ready = 1;
    @(negedge clk);
    chk("t4_ready_freeze", bus.pipe_freeze, 0);
    chk("t4_ready_state", bus.hz_state, 2'b10);
    cyc(); idle();
    @(negedge clk);
    chk("t4_final_state", bus.hz_state, 2'b00);
    chk("t4_stall_cnt", bus.stall_cnt, 3);

    // timeout into ERR, then asynchronous reset recovery
    pulse_reset();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < MT; i++) begin
      @(negedge clk);
      chk("t5_freeze", bus.pipe_freeze, 1);
      chk("t5_no_err", bus.mem_err, 0);
      cyc();
    end
    @(negedge clk);
    chk("t5_err_state", bus.hz_state, 2'b11);
    chk("t5_mem_err", bus.mem_err, 1);
    bus.dmem_req = 0;
    repeat (20) cyc();
    @(negedge clk);
    chk("t5_err_hold", bus.pipe_freeze, 1);
    chk("t5_stall_hold", bus.stall_cnt, MT);
    cyc(); reset = 1'b1;
    #1;
    chk("t5_rst_state", bus.hz_state, 2'b00);
    chk("t5_rst_err", bus.mem_err, 0);
    chk("t5_rst_stall", bus.stall_cnt, 0);
    cyc(); reset = 1'b0; idle();

    // freeze masks the load-use bubble; stall appears on the ready cycle
    cyc(); load_use_on(); bus.dmem_req = 1; bus.dmem_ready = 0;
    @(negedge clk);
    chk("t6_freeze", bus.pipe_freeze, 1);
    chk("t6_no_bubble", bus.id_ex_bubble, 0);
    cyc(); bus.dmem_ready = 1;
    @(negedge clk);
    chk("t6_after_freeze", bus.pipe_freeze, 0);
    chk("t6_after_bubble", bus.id_ex_bubble, 1);
    cyc(); idle();

    hold_lo = 0;
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if (reset) reset = 1'b0;
      else if ($urandom_range(99) == 0) reset = 1'b1;
      bus.id_Rn       = pick();
      bus.id_Rm       = pick();
      bus.id_Rd       = pick();
      bus.ex_Rd       = pick();
      bus.id_Reg2Loc  = 1'($urandom_range(1));
      bus.id_reads_Ra = 1'($urandom_range(1));
      bus.id_reads_Rb = 1'($urandom_range(1));
      bus.id_is_bcond = ($urandom_range(3) == 0);
      bus.id_br_taken = ($urandom_range(2) == 0);
      bus.ex_RegWren  = 1'($urandom_range(1));
      bus.ex_Mem2Reg  = 1'($urandom_range(1));
      bus.ex_SetFlags = ($urandom_range(3) == 0);
      bus.dmem_req    = ($urandom_range(4) == 0);
      if (hold_lo > 0) begin
        bus.dmem_ready = 0;
        hold_lo--;
      end else begin
        bus.dmem_ready = ($urandom_range(2) != 0);
        if ($urandom_range(40) == 0) hold_lo = 6;
      end
    end
    cyc(); idle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
